// File: rtl/rlbp_pkg.sv
// Shared register map, STATUS/CTRL bit positions and receiver FSM encoding
// for the RLBP serial-to-parallel receiver.
package rlbp_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef struct packed {
        logic [7:0] div;
        logic       irq_en;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN] = c.en;
        w[CTRL_IRQ_EN] = c.irq_en;
        w[CTRL_DIV_LSB +: 8] = c.div;
        return w;
    endfunction

endpackage

// File: rtl/rlbp_byte_fifo.sv
// Byte FIFO; a pop and a push in the same cycle both succeed even when full.
module rlbp_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop, do_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign count  = cnt_q;
    assign dout   = mem_q[rd_q];
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rlbp_s2p_rx.sv
// RLBP serial receiver: mid-bit sampling FSM feeding a byte FIFO, with a
// Wishbone slave exposing DATA/STATUS/CTRL registers and a level interrupt.
module rlbp_s2p_rx
    import rlbp_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] ADDR_TAG = 4'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq,
    output logic        rx_busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic        serial_q;
    ctrl_t       ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d;
    logic        ack_q, held_q;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic          frame_push, frame_err;
    logic          wb_valid, wb_go, wb_rd, wb_wr;
    logic [1:0]    reg_sel;
    logic          fifo_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [3:0]    cnt4;
    logic          unused_ok;

    assign unused_ok = ^{wbs_adr_i[27:4], wbs_adr_i[1:0], wbs_sel_i[3:2],
                         wbs_dat_i[31:16], wbs_dat_i[7:4]};

    // Sampling uses serial_q so the START check at floor(DIV/2) still lands
    // inside the start bit when DIV is 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitn_d     = bitn_q;
        shift_d    = shift_q;
        frame_push = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (serial_in) begin
                    state_d = ST_START;
                    cnt_d   = ctrl_q.div >> 1;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (serial_q) begin
                    state_d = ST_DATA;
                    cnt_d   = ctrl_q.div;
                    bitn_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {shift_q[6:0], serial_q};
                    cnt_d   = ctrl_q.div;
                    bitn_d  = bitn_q + 1'b1;
                    if (bitn_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    frame_push = ~serial_q;
                    frame_err  = serial_q;
                    state_d    = ST_IDLE;
                end
            end
        endcase
        if (!ctrl_q.en) begin
            state_d    = ST_IDLE;
            frame_push = 1'b0;
            frame_err  = 1'b0;
        end
    end

    assign wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == ADDR_TAG);
    assign wb_go    = wb_valid & ~held_q;
    assign wb_rd    = wb_go & ~wbs_we_i;
    assign wb_wr    = wb_go & wbs_we_i;
    assign reg_sel  = wbs_adr_i[3:2];
    assign fifo_pop = wb_rd & (reg_sel == REG_DATA);
    assign cnt4     = 4'(fifo_count);

    always_comb begin
        dat_d  = '0;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        if (wb_rd) begin
            case (reg_sel)
                REG_DATA:   dat_d = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                REG_STATUS: begin
                    dat_d[STAT_EMPTY] = fifo_empty;
                    dat_d[STAT_FULL]  = fifo_full;
                    dat_d[STAT_OVF]   = ovf_q;
                    dat_d[STAT_FERR]  = ferr_q;
                    dat_d[STAT_CNT_LSB +: 4] = cnt4;
                end
                REG_CTRL:   dat_d = ctrl_word(ctrl_q);
                default:    dat_d = '0;
            endcase
        end
        if (wb_wr && reg_sel == REG_STATUS && wbs_sel_i[0]) begin
            if (wbs_dat_i[STAT_OVF])  ovf_d  = 1'b0;
            if (wbs_dat_i[STAT_FERR]) ferr_d = 1'b0;
        end
        if (wb_wr && reg_sel == REG_CTRL) begin
            if (wbs_sel_i[0]) begin
                ctrl_d.en     = wbs_dat_i[CTRL_EN];
                ctrl_d.irq_en = wbs_dat_i[CTRL_IRQ_EN];
            end
            if (wbs_sel_i[1]) begin
                ctrl_d.div = wbs_dat_i[CTRL_DIV_LSB +: 8];
            end
        end
        // A flag raised in the same cycle as its W1C clear is kept.
        if (frame_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (frame_err) ferr_d = 1'b1;
        irq_d = ctrl_q.irq_en & (~fifo_empty | ovf_q | ferr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitn_q   <= '0;
            shift_q  <= '0;
            serial_q <= 1'b0;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ack_q    <= 1'b0;
            held_q   <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitn_q   <= bitn_d;
            shift_q  <= shift_d;
            serial_q <= serial_in;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            ack_q    <= wb_go;
            held_q   <= wb_valid;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    rlbp_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (frame_push),
        .din   (shift_q),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule
